// File: rtl/avmm_multi_interval_timer_pkg.sv
// Shared definitions for the multi-channel interval timer: register indices, bit positions, channel write request.
// The TIMER_PRESCALER_EN macro adds the prescale write strobe to the request.
package avmm_timer_pkg;

    localparam logic [2:0] REG_STATUS   = 3'd0;
    localparam logic [2:0] REG_CONTROL  = 3'd1;
    localparam logic [2:0] REG_PERIOD   = 3'd2;
    localparam logic [2:0] REG_SNAP     = 3'd3;
    localparam logic [2:0] REG_PRESCALE = 3'd4;

    localparam int CTL_ITO   = 0;
    localparam int CTL_CONT  = 1;
    localparam int CTL_START = 2;
    localparam int CTL_STOP  = 3;

    localparam int ST_TO  = 0;
    localparam int ST_RUN = 1;

    typedef struct packed {
        logic        wr_status;
        logic        wr_control;
        logic        wr_period;
        logic        wr_snap;
`ifdef TIMER_PRESCALER_EN
        logic        wr_prescale;
`endif
        logic [31:0] wdata;
    } ch_req_t;

endpackage

// File: rtl/avmm_multi_interval_timer_if.sv
// Avalon-MM slave bus bundle for the multi-channel interval timer.
interface avmm_multi_interval_timer_if #(
    parameter int ADDR_W = 5
);
    logic [ADDR_W-1:0] address;
    logic              chipselect;
    logic              write_n;
    logic [31:0]       writedata;
    logic [31:0]       readdata;

    modport master (output address, chipselect, write_n, writedata, input readdata);
    modport slave  (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/avmm_multi_interval_timer_channel.sv
// One timer channel: down-counter, PERIOD/SNAP/CONTROL registers, TO/RUN flags.
// TIMER_PRESCALER_EN adds an 8-bit PRESCALE register and tick divider.
module avmm_timer_channel
    import avmm_timer_pkg::*;
#(
    parameter int               CNT_W      = 32,
    parameter logic [CNT_W-1:0] RST_PERIOD = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  ch_req_t          req_i,
    output logic [CNT_W-1:0] period_o,
    output logic [CNT_W-1:0] snap_o,
    output logic [3:0]       ctl_o,
    output logic             to_o,
    output logic             run_o
`ifdef TIMER_PRESCALER_EN
    ,
    output logic [7:0]       psc_o
`endif
);

    logic [CNT_W-1:0] cnt_q, cnt_d, period_q, period_d, snap_q, snap_d;
    logic [3:0]       ctl_q, ctl_d;
    logic             to_q, to_d, run_q, run_d, fr_q, zero_q;
    logic             start, stop, zero, tmo, tick;

    assign start = req_i.wr_control & req_i.wdata[CTL_START];
    assign stop  = req_i.wr_control & req_i.wdata[CTL_STOP];
    assign zero  = (cnt_q == '0);
    // Only the rising edge of zero is an event, so PERIOD=0 in CONT mode fires once.
    assign tmo   = zero & ~zero_q;

`ifdef TIMER_PRESCALER_EN
    logic [7:0] psc_q, psc_d, pcnt_q, pcnt_d;

    assign tick  = (pcnt_q == psc_q);
    assign psc_o = psc_q;

    always_comb begin
        psc_d  = req_i.wr_prescale ? req_i.wdata[7:0] : psc_q;
        pcnt_d = pcnt_q;
        if (fr_q | start | stop) pcnt_d = '0;
        else if (run_q)          pcnt_d = tick ? 8'd0 : pcnt_q + 8'd1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            psc_q  <= '0;
            pcnt_q <= '0;
        end else begin
            psc_q  <= psc_d;
            pcnt_q <= pcnt_d;
        end
    end
`else
    assign tick = 1'b1;
`endif

    always_comb begin
        cnt_d    = cnt_q;
        run_d    = run_q;
        period_d = req_i.wr_period  ? req_i.wdata[CNT_W-1:0] : period_q;
        snap_d   = req_i.wr_snap    ? cnt_q : snap_q;
        ctl_d    = req_i.wr_control ? req_i.wdata[3:0] : ctl_q;
        // Set beats clear so a timeout coinciding with a STATUS write is not lost.
        to_d     = tmo | (to_q & ~req_i.wr_status);

        if (fr_q) begin
            cnt_d = period_q;
        end else if (run_q && tick) begin
            if (!zero)                  cnt_d = cnt_q - CNT_W'(1);
            else if (ctl_q[CTL_CONT])   cnt_d = period_q;
        end

        if (fr_q)                                   run_d = 1'b0;
        else if (start)                             run_d = 1'b1;
        else if (stop)                              run_d = 1'b0;
        else if (run_q && zero && !ctl_q[CTL_CONT]) run_d = 1'b0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q    <= RST_PERIOD;
            period_q <= RST_PERIOD;
            snap_q   <= '0;
            ctl_q    <= '0;
            to_q     <= 1'b0;
            run_q    <= 1'b0;
            fr_q     <= 1'b0;
            zero_q   <= (RST_PERIOD == '0);
        end else begin
            cnt_q    <= cnt_d;
            period_q <= period_d;
            snap_q   <= snap_d;
            ctl_q    <= ctl_d;
            to_q     <= to_d;
            run_q    <= run_d;
            fr_q     <= req_i.wr_period;
            zero_q   <= zero;
        end
    end

    assign period_o = period_q;
    assign snap_o   = snap_q;
    assign ctl_o    = ctl_q;
    assign to_o     = to_q;
    assign run_o    = run_q;

endmodule

// File: rtl/avmm_multi_interval_timer.sv
// NUM_CH-channel Avalon-MM interval timer: address decode, registered read mux, irq combine.
// TIMER_PRESCALER_EN enables the per-channel PRESCALE register (reg 4).
module avmm_multi_interval_timer
    import avmm_timer_pkg::*;
#(
    parameter int          NUM_CH     = 4,
    parameter int          CNT_W      = 32,
    parameter int unsigned RST_PERIOD = 47999
) (
    input  logic                        clk,
    input  logic                        reset_n,
    avmm_multi_interval_timer_if.slave  bus,
    output logic                        irq,
    output logic [NUM_CH-1:0]           irq_vec
);

    localparam logic [CNT_W-1:0] RST_P = CNT_W'(RST_PERIOD);

    logic [3:0]  ch_idx;
    logic [2:0]  reg_idx;
    logic        wr;
    logic [31:0] rdata_d, rdata_q;

    logic [NUM_CH-1:0][CNT_W-1:0] period_v, snap_v;
    logic [NUM_CH-1:0][3:0]       ctl_v;
    logic [NUM_CH-1:0]            to_v, run_v;
`ifdef TIMER_PRESCALER_EN
    logic [NUM_CH-1:0][7:0]       psc_v;
`endif

    assign reg_idx = bus.address[2:0];
    assign ch_idx  = 4'(bus.address >> 3);
    assign wr      = bus.chipselect & ~bus.write_n;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic    hit;
        ch_req_t req;

        assign hit            = wr && (int'(ch_idx) == c);
        assign req.wr_status  = hit && (reg_idx == REG_STATUS);
        assign req.wr_control = hit && (reg_idx == REG_CONTROL);
        assign req.wr_period  = hit && (reg_idx == REG_PERIOD);
        assign req.wr_snap    = hit && (reg_idx == REG_SNAP);
`ifdef TIMER_PRESCALER_EN
        assign req.wr_prescale = hit && (reg_idx == REG_PRESCALE);
`endif
        assign req.wdata      = bus.writedata;

        avmm_timer_channel #(
            .CNT_W      (CNT_W),
            .RST_PERIOD (RST_P)
        ) u_ch (
            .clk      (clk),
            .reset_n  (reset_n),
            .req_i    (req),
            .period_o (period_v[c]),
            .snap_o   (snap_v[c]),
            .ctl_o    (ctl_v[c]),
            .to_o     (to_v[c]),
            .run_o    (run_v[c])
`ifdef TIMER_PRESCALER_EN
            ,
            .psc_o    (psc_v[c])
`endif
        );

        assign irq_vec[c] = to_v[c] & ctl_v[c][CTL_ITO];
    end

    assign irq = |irq_vec;

    // Out-of-range channels and reserved registers fall through to zero.
    always_comb begin
        rdata_d = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (int'(ch_idx) == c) begin
                case (reg_idx)
                    REG_STATUS: begin
                        rdata_d[ST_TO]  = to_v[c];
                        rdata_d[ST_RUN] = run_v[c];
                    end
                    REG_CONTROL:  rdata_d = 32'(ctl_v[c]);
                    REG_PERIOD:   rdata_d = 32'(period_v[c]);
                    REG_SNAP:     rdata_d = 32'(snap_v[c]);
`ifdef TIMER_PRESCALER_EN
                    REG_PRESCALE: rdata_d = 32'(psc_v[c]);
`endif
                    default:      rdata_d = '0;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) rdata_q <= '0;
        else          rdata_q <= rdata_d;
    end

    assign bus.readdata = rdata_q;

endmodule

// File: tb/tb_avmm_multi_interval_timer.sv
// Directed plus randomized bench for avmm_multi_interval_timer against a cycle-level behavioural model.
module tb_avmm_multi_interval_timer;
    import avmm_timer_pkg::*;

    localparam int NUM_CH = 4;
    localparam int CNT_W  = 32;
    localparam int AW     = $clog2(NUM_CH) + 3;
    localparam logic [31:0] RSTP = 32'd47999;

    logic              clk, reset_n, irq;
    logic [NUM_CH-1:0] irq_vec;
    int                checks, errors;

    avmm_multi_interval_timer_if #(.ADDR_W(AW)) bus ();

    avmm_multi_interval_timer #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .RST_PERIOD(47999)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave),
        .irq     (irq),
        .irq_vec (irq_vec)
    );

    always #5 clk = ~clk;

    // reference state of each channel
    logic [31:0] m_cnt [NUM_CH];
    logic [31:0] m_per [NUM_CH];
    logic [31:0] m_snap[NUM_CH];
    logic [3:0]  m_ctl [NUM_CH];
    logic [7:0]  m_psc [NUM_CH];
    logic [7:0]  m_pc  [NUM_CH];
    bit          m_to[NUM_CH], m_run[NUM_CH], m_fr[NUM_CH], m_zp[NUM_CH];
    logic [31:0] m_rd;

    function automatic void mreset();
        for (int c = 0; c < NUM_CH; c++) begin
            m_cnt[c] = RSTP; m_per[c] = RSTP; m_snap[c] = 0; m_ctl[c] = 0;
            m_psc[c] = 0; m_pc[c] = 0; m_to[c] = 0; m_run[c] = 0; m_fr[c] = 0; m_zp[c] = 0;
        end
        m_rd = 0;
    endfunction

    function automatic void mstep();
        bit          wr;
        int          ch, rg;
        logic [31:0] wd;
        wr = bus.chipselect && !bus.write_n;
        ch = int'(bus.address) / 8;
        rg = int'(bus.address) % 8;
        wd = bus.writedata;
        m_rd = 0;
        if (ch < NUM_CH) begin
            case (rg)
                0: m_rd = {30'd0, m_run[ch], m_to[ch]};
                1: m_rd = {28'd0, m_ctl[ch]};
                2: m_rd = m_per[ch];
                3: m_rd = m_snap[ch];
`ifdef TIMER_PRESCALER_EN
                4: m_rd = {24'd0, m_psc[ch]};
`endif
                default: m_rd = 0;
            endcase
        end
        for (int c = 0; c < NUM_CH; c++) begin
            bit          hit, start, stop, zero, ev, tick, nr;
            logic [31:0] nc;
            hit   = wr && (ch == c);
            start = hit && rg == 1 && wd[2];
            stop  = hit && rg == 1 && wd[3];
            zero  = (m_cnt[c] == 0);
            ev    = zero && !m_zp[c];
`ifdef TIMER_PRESCALER_EN
            tick  = (m_pc[c] == m_psc[c]);
            if (m_fr[c] || start || stop) m_pc[c] = 0;
            else if (m_run[c])            m_pc[c] = tick ? 8'd0 : m_pc[c] + 8'd1;
            if (hit && rg == 4) m_psc[c] = wd[7:0];
`else
            tick  = 1;
`endif
            nc = m_cnt[c];
            nr = m_run[c];
            if (m_fr[c]) begin
                nc = m_per[c];
                nr = 0;
            end else begin
                if (m_run[c] && tick) nc = zero ? (m_ctl[c][1] ? m_per[c] : 32'd0) : m_cnt[c] - 1;
                if (start)                               nr = 1;
                else if (stop)                           nr = 0;
                else if (m_run[c] && zero && !m_ctl[c][1]) nr = 0;
            end
            if (hit && rg == 3) m_snap[c] = m_cnt[c];
            m_to[c] = ev || (m_to[c] && !(hit && rg == 0));
            if (hit && rg == 1) m_ctl[c] = wd[3:0];
            if (hit && rg == 2) m_per[c] = wd;
            m_fr[c]  = hit && rg == 2;
            m_zp[c]  = zero;
            m_cnt[c] = nc;
            m_run[c] = nr;
        end
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic check_all();
        logic [NUM_CH-1:0] ev;
        for (int c = 0; c < NUM_CH; c++) ev[c] = m_to[c] & m_ctl[c][0];
        chk("rdata", bus.readdata, m_rd);
        chk("irq_vec", 32'(irq_vec), 32'(ev));
        chk("irq", 32'(irq), 32'(|ev));
    endtask

    task automatic cyc();
        @(posedge clk);
        if (reset_n) mstep();
        @(negedge clk);
        check_all();
    endtask

    task automatic wr(input int a, input logic [31:0] d);
        bus.address = AW'(a); bus.chipselect = 1; bus.write_n = 0; bus.writedata = d;
        cyc();
        bus.chipselect = 0; bus.write_n = 1;
    endtask

    task automatic rd(input int a, output logic [31:0] v);
        bus.address = AW'(a);
        cyc();
        v = bus.readdata;
    endtask

    initial begin
        logic [31:0] v, d;
        int          lat, a, rg;
        bit          found;
        checks = 0; errors = 0;
        clk = 0; reset_n = 0;
        bus.address = '0; bus.chipselect = 0; bus.write_n = 1; bus.writedata = '0;
        mreset();
        repeat (3) cyc();
        reset_n = 1;

        // reset state
        rd(2, v);  chk("rst_period", v, 32'd47999);
        rd(0, v);  chk("rst_status", v, 32'd0);
        chk("rst_irq", 32'(irq), 32'd0);

        // ch1 continuous, PERIOD=5
        wr(10, 5); cyc(); wr(9, 6);
        bus.address = AW'(8); found = 0; lat = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            cyc();
            if (bus.readdata[0]) begin found = 1; lat = i + 1; end
        end
        chk("ch1_to_seen", 32'(found), 32'd1);
        chk("ch1_to_lat", lat, 32'd7);
        repeat (8) cyc();
        chk("ch1_irq_ito0", 32'(irq), 32'd0);
        wr(9, 7);
        chk("ch1_irq", 32'(irq), 32'd1);
        chk("ch1_irqv", 32'(irq_vec[1]), 32'd1);

        // ch2 one-shot, PERIOD=3
        wr(18, 3); cyc(); wr(17, 5);
        repeat (10) cyc();
        rd(16, v); chk("ch2_status", v, 32'd1);
        wr(19, 0); rd(19, v); chk("ch2_snap0", v, 32'd0);
        chk("ch2_irqv_set", 32'(irq_vec[2]), 32'd1);
        wr(16, 0);
        chk("ch2_irqv_clr", 32'(irq_vec[2]), 32'd0);

        // ch0 force reload while running
        wr(1, 6); repeat (3) cyc();
        wr(2, 10); cyc();
        wr(3, 0); rd(3, v); chk("ch0_snap", v, 32'd10);
        rd(0, v); chk("ch0_run_clr", 32'(v[1]), 32'd0);

        // ch3: STATUS write in the same cycle as the timeout
        wr(26, 4); cyc(); wr(25, 4);
        found = 0;
        for (int i = 0; i < 20; i++) begin
            if (m_cnt[3] == 0 && !m_zp[3]) begin found = 1; wr(24, 0); break; end
            cyc();
        end
        chk("ch3_coincide_found", 32'(found), 32'd1);
        rd(24, v); chk("ch3_to_kept", 32'(v[0]), 32'd1);
        wr(25, 32'hC); rd(24, v); chk("ch3_start_wins", 32'(v[1]), 32'd1);

        // reg 4 and reserved regs
        wr(4, 32'hFF); rd(4, v);
`ifdef TIMER_PRESCALER_EN
        chk("reg4", v, 32'hFF);
        wr(4, 0);
`else
        chk("reg4", v, 32'd0);
`endif
        wr(5, 32'hDEAD); rd(5, v); chk("reserved", v, 32'd0);

        // asynchronous reset mid-count
        wr(9, 6); repeat (4) cyc();
        #2 reset_n = 0; mreset();
        #1;
        chk("arst_rdata", bus.readdata, 32'd0);
        chk("arst_irq", 32'(irq), 32'd0);
        chk("arst_irqv", 32'(irq_vec), 32'd0);
        @(negedge clk);
        repeat (2) cyc();
        reset_n = 1;
        rd(10, v); chk("arst_period", v, 32'd47999);
        rd(8, v);  chk("arst_status", v, 32'd0);

        // randomized traffic against the model
        for (int i = 0; i < 1500; i++) begin
            a  = int'($urandom_range(0, 8 * NUM_CH - 1));
            rg = a % 8;
            if ($urandom_range(0, 1) == 0) begin
                bus.address = AW'(a);
                bus.chipselect = $urandom_range(0, 1) == 1;
                bus.write_n = bus.chipselect ? 1'b1 : 1'($urandom_range(0, 1));
                bus.writedata = $urandom;
                cyc();
                bus.chipselect = 0; bus.write_n = 1;
            end else begin
                if (rg == 1)      d = $urandom_range(0, 15);
                else if (rg == 2) d = $urandom_range(0, 12);
`ifdef TIMER_PRESCALER_EN
                else if (rg == 4) d = $urandom_range(0, 3);
`endif
                else              d = $urandom;
                wr(a, d);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
